// File: rtl/outer_loop_ctrl.sv
// Digit sequencer for inner_loop_new: slices B into DIGIT_W digits and issues them LSB-first.
// Optional build macro OUTER_CTRL_SKIP_ZERO_EN: all-zero digits are reported as skipped, not issued.
module outer_loop_ctrl #(
  parameter int DIGIT_W  = 78,
  parameter int N_DIGITS = 40,
  parameter int IDX_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGIT_W*N_DIGITS-1:0] b_in,
  input  logic                        abort,
  output logic [DIGIT_W-1:0]          il_bi,
  output logic                        il_en,
  input  logic                        il_en_out,
  output logic [IDX_W-1:0]            dig_idx,
  output logic                        dig_done,
  output logic                        dig_skip,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int B_W = DIGIT_W * N_DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

`ifdef OUTER_CTRL_SKIP_ZERO_EN
  function automatic logic digit_is_zero(input logic [DIGIT_W-1:0] d);
    return (d == {DIGIT_W{1'b0}});
  endfunction
`endif

  logic [1:0]         state_q, state_d;
  logic [B_W-1:0]     shift_q, shift_d;
  logic [DIGIT_W-1:0] il_bi_q, il_bi_d;
  logic               il_en_q, il_en_d;
  logic [IDX_W-1:0]   dig_idx_q, dig_idx_d;
  logic               dig_done_q, dig_done_d;
  logic               dig_skip_q, dig_skip_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   cur_idx_s;
  logic               abort_s;
  logic               start_acc_s;
  logic               err_set_s;

  // Next-state and next-output logic for the issue/wait sequencer
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    il_bi_d    = il_bi_q;
    il_en_d    = 1'b0;
    dig_idx_d  = dig_idx_q;
    dig_done_d = 1'b0;
    dig_skip_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    // dig_idx advances one cycle after dig_done so the pulse reports the finished digit
    cur_idx_s   = dig_done_q ? (dig_idx_q + IDX_W'(1)) : dig_idx_q;
    abort_s     = abort && (state_q != S_IDLE);
    start_acc_s = start && (state_q == S_IDLE);
    err_set_s   = il_en_out && (state_q != S_WAIT);

    if (abort_s) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_d   = b_in;
            dig_idx_d = {IDX_W{1'b0}};
            busy_d    = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            busy_d = 1'b0;
          end
        end
        S_ISSUE: begin
          dig_idx_d = cur_idx_s;
`ifdef OUTER_CTRL_SKIP_ZERO_EN
          if (digit_is_zero(shift_q[DIGIT_W-1:0])) begin
            dig_done_d = 1'b1;
            dig_skip_d = 1'b1;
            shift_d    = shift_q >> DIGIT_W;
            if (cur_idx_s == LAST_IDX) begin
              state_d = S_FIN;
            end else begin
              state_d = S_ISSUE;
            end
          end else begin
            il_en_d = 1'b1;
            il_bi_d = shift_q[DIGIT_W-1:0];
            state_d = S_WAIT;
          end
`else
          il_en_d = 1'b1;
          il_bi_d = shift_q[DIGIT_W-1:0];
          state_d = S_WAIT;
`endif
        end
        S_WAIT: begin
          if (il_en_out) begin
            dig_done_d = 1'b1;
            if (dig_idx_q == LAST_IDX) begin
              state_d = S_FIN;
            end else begin
              shift_d = shift_q >> DIGIT_W;
              state_d = S_ISSUE;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_FIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // A stray completion is flagged even on the cycle that would clear the flag
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (start_acc_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= {B_W{1'b0}};
      il_bi_q    <= {DIGIT_W{1'b0}};
      il_en_q    <= 1'b0;
      dig_idx_q  <= {IDX_W{1'b0}};
      dig_done_q <= 1'b0;
      dig_skip_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      il_bi_q    <= il_bi_d;
      il_en_q    <= il_en_d;
      dig_idx_q  <= dig_idx_d;
      dig_done_q <= dig_done_d;
      dig_skip_q <= dig_skip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign il_bi    = il_bi_q;
  assign il_en    = il_en_q;
  assign dig_idx  = dig_idx_q;
  assign dig_done = dig_done_q;
  assign dig_skip = dig_skip_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
